// File: rtl/cv32e40p_tmr_health_voter.sv
// TMR voter with per-replica health tracking: bitwise majority over healthy
// replicas, consecutive-error accounting and sticky BROKEN exclusion.
module cv32e40p_tmr_health_voter #(
  parameter int unsigned L1         = 32,
  parameter int unsigned NOUT       = 1,
  parameter int unsigned ERR_THRESH = 4,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned REG_OUT    = 0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       valid_i,
  input  logic [2:0][L1-1:0]         to_vote_i,
  input  logic [2:0]                 broken_block_i,
  input  logic [2:0]                 clear_i,
  output logic [NOUT-1:0][L1-1:0]    voted_o,
  output logic [2:0]                 block_err_o,
  output logic                       err_detected_o,
  output logic                       err_corrected_o,
  output logic                       err_uncorrectable_o,
  output logic [2:0]                 broken_o,
  output logic                       fatal_o,
  output logic [CNT_W-1:0]           err_cnt_o
);

  typedef enum logic [1:0] {HEALTHY, SUSPECT, BROKEN} hstate_e;

  hstate_e                state_q [3];
  hstate_e                state_d [3];
  logic [2:0][CNT_W-1:0]  consec_q, consec_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   unc_q, unc_d;

  logic [2:0]             brk_int, brk_eff, block_err_c, hit;
  logic [1:0]             nb;
  logic [NOUT-1:0][L1-1:0] voted_c;
  logic                   all_diff, det_c, corr_c, unc_c;

  // Majority when nothing is excluded, otherwise the lowest-index healthy replica.
  function automatic logic [L1-1:0] vote_word(input logic [2:0][L1-1:0] w,
                                              input logic [2:0]         b);
    logic [L1-1:0] r;
    case (b)
      3'b000:  r = (w[0] & w[1]) | (w[0] & w[2]) | (w[1] & w[2]);
      3'b001:  r = w[1];
      3'b011:  r = w[2];
      3'b101:  r = w[1];
      default: r = w[0];
    endcase
    return r;
  endfunction

  always_comb begin
    for (int k = 0; k < 3; k++) brk_int[k] = (state_q[k] == BROKEN);
  end

  assign brk_eff = brk_int | broken_block_i;
  assign nb      = 2'(brk_eff[0]) + 2'(brk_eff[1]) + 2'(brk_eff[2]);

  for (genvar i = 0; i < NOUT; i++) begin : g_copy
    assign voted_c[i] = vote_word(to_vote_i, brk_eff);
  end

  always_comb begin
    for (int k = 0; k < 3; k++)
      block_err_c[k] = !brk_eff[k] && (nb < 2'd2) && (to_vote_i[k] != voted_c[0]);
  end

  assign all_diff = (to_vote_i[0] != to_vote_i[1]) && (to_vote_i[1] != to_vote_i[2]) &&
                    (to_vote_i[0] != to_vote_i[2]);
  assign det_c    = |block_err_c;
  assign corr_c   = (nb == 2'd0) && det_c && !all_diff;
  assign unc_c    = ((nb == 2'd0) && all_diff) || ((nb == 2'd1) && det_c);
  assign hit      = corr_c ? block_err_c : 3'b000;

  // Health FSMs: clear wins over a same-cycle error; only valid cycles advance.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      state_d[k]  = state_q[k];
      consec_d[k] = consec_q[k];
      if (clear_i[k]) begin
        state_d[k]  = HEALTHY;
        consec_d[k] = '0;
      end else if (valid_i) begin
        case (state_q[k])
          HEALTHY: if (hit[k]) begin
            consec_d[k] = CNT_W'(1);
            state_d[k]  = (ERR_THRESH == 1) ? BROKEN : SUSPECT;
          end
          SUSPECT: if (hit[k]) begin
            consec_d[k] = consec_q[k] + CNT_W'(1);
            if (consec_q[k] + CNT_W'(1) >= CNT_W'(ERR_THRESH)) state_d[k] = BROKEN;
          end else begin
            consec_d[k] = '0;
            state_d[k]  = HEALTHY;
          end
          BROKEN:  state_d[k] = BROKEN;
          default: begin
            state_d[k]  = HEALTHY;
            consec_d[k] = '0;
          end
        endcase
      end
    end
    cnt_d = cnt_q;
    if (valid_i && corr_c && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
    unc_d = unc_q | (valid_i && unc_c);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < 3; k++) begin
        state_q[k]  <= HEALTHY;
        consec_q[k] <= '0;
      end
      cnt_q <= '0;
      unc_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      consec_q <= consec_d;
      cnt_q    <= cnt_d;
      unc_q    <= unc_d;
    end
  end

  assign broken_o            = brk_eff;
  assign fatal_o             = (nb >= 2'd2);
  assign err_cnt_o           = cnt_q;
  assign err_uncorrectable_o = unc_q;

  if (REG_OUT != 0) begin : g_reg
    logic [NOUT-1:0][L1-1:0] voted_q;
    logic [2:0]              block_err_q;
    logic                    det_q, corr_q;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        voted_q     <= '0;
        block_err_q <= '0;
        det_q       <= 1'b0;
        corr_q      <= 1'b0;
      end else begin
        voted_q     <= voted_c;
        block_err_q <= block_err_c;
        det_q       <= det_c;
        corr_q      <= corr_c;
      end
    end

    assign voted_o         = voted_q;
    assign block_err_o     = block_err_q;
    assign err_detected_o  = det_q;
    assign err_corrected_o = corr_q;
  end else begin : g_comb
    assign voted_o         = voted_c;
    assign block_err_o     = block_err_c;
    assign err_detected_o  = det_c;
    assign err_corrected_o = corr_c;
  end

endmodule

// File: tb/tb_cv32e40p_tmr_health_voter.sv
// Directed bench: main voter (NOUT=3), a CNT_W=2 instance for saturation and
// a REG_OUT=1 instance for output latency, all driven from shared inputs.
module tb_cv32e40p_tmr_health_voter;
  localparam int L1 = 32;

  logic                clk = 1'b0;
  logic                rst, valid;
  logic [2:0][L1-1:0]  tv;
  logic [2:0]          bb, clr;

  logic [2:0][L1-1:0]  m_voted;
  logic [2:0]          m_berr, m_broken;
  logic                m_det, m_corr, m_unc, m_fatal;
  logic [7:0]          m_cnt;

  logic [0:0][L1-1:0]  s_voted;
  logic [2:0]          s_berr, s_broken;
  logic                s_det, s_corr, s_unc, s_fatal;
  logic [1:0]          s_cnt;

  logic [0:0][L1-1:0]  r_voted;
  logic [2:0]          r_berr, r_broken;
  logic                r_det, r_corr, r_unc, r_fatal;
  logic [7:0]          r_cnt;

  int errors = 0;
  int checks = 0;

  cv32e40p_tmr_health_voter #(.L1(L1), .NOUT(3), .ERR_THRESH(4), .CNT_W(8), .REG_OUT(0)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .to_vote_i(tv), .broken_block_i(bb),
    .clear_i(clr), .voted_o(m_voted), .block_err_o(m_berr), .err_detected_o(m_det),
    .err_corrected_o(m_corr), .err_uncorrectable_o(m_unc), .broken_o(m_broken),
    .fatal_o(m_fatal), .err_cnt_o(m_cnt));

  cv32e40p_tmr_health_voter #(.L1(L1), .NOUT(1), .ERR_THRESH(3), .CNT_W(2), .REG_OUT(0)) dut_s (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .to_vote_i(tv), .broken_block_i(bb),
    .clear_i(clr), .voted_o(s_voted), .block_err_o(s_berr), .err_detected_o(s_det),
    .err_corrected_o(s_corr), .err_uncorrectable_o(s_unc), .broken_o(s_broken),
    .fatal_o(s_fatal), .err_cnt_o(s_cnt));

  cv32e40p_tmr_health_voter #(.L1(L1), .NOUT(1), .ERR_THRESH(4), .CNT_W(8), .REG_OUT(1)) dut_r (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .to_vote_i(tv), .broken_block_i(bb),
    .clear_i(clr), .voted_o(r_voted), .block_err_o(r_berr), .err_detected_o(r_det),
    .err_corrected_o(r_corr), .err_uncorrectable_o(r_unc), .broken_o(r_broken),
    .fatal_o(r_fatal), .err_cnt_o(r_cnt));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_vote(input string tag, input logic [31:0] exp);
    for (int i = 0; i < 3; i++) chk($sformatf("%s[%0d]", tag, i), m_voted[i], exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setw(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    tv[0] = a;
    tv[1] = b;
    tv[2] = c;
    #1;
  endtask

  localparam logic [31:0] GOOD = 32'hDEADBEEF;
  localparam logic [31:0] BAD1 = 32'hDEADBEEE;

  initial begin
    rst = 1'b1; valid = 1'b0; bb = 3'b000; clr = 3'b000;
    setw(32'h0, 32'h0, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    chk("rst_broken", 32'(m_broken), 32'h0);
    chk("rst_cnt", 32'(m_cnt), 32'h0);
    chk("rst_unc", 32'(m_unc), 32'h0);
    chk("rst_fatal", 32'(m_fatal), 32'h0);
    chk("rst_r_voted", r_voted[0], 32'h0);
    chk("rst_r_berr", 32'(r_berr), 32'h0);
    chk("rst_s_cnt", 32'(s_cnt), 32'h0);

    // all replicas agree
    valid = 1'b1;
    setw(GOOD, GOOD, GOOD);
    chk_vote("clean_voted", GOOD);
    chk("clean_berr", 32'(m_berr), 32'h0);
    chk("clean_det", 32'(m_det), 32'h0);
    chk("clean_corr", 32'(m_corr), 32'h0);
    chk("r_voted_lag0", r_voted[0], 32'h0);
    tick();
    chk("r_voted_lag1", r_voted[0], GOOD);
    chk("clean_cnt1", 32'(m_cnt), 32'h0);
    tick();
    chk("clean_cnt2", 32'(m_cnt), 32'h0);

    // replica 1 off by one bit for 3 cycles
    setw(GOOD, BAD1, GOOD);
    chk_vote("r1_voted", GOOD);
    chk("r1_berr", 32'(m_berr), 32'h2);
    chk("r1_det", 32'(m_det), 32'h1);
    chk("r1_corr", 32'(m_corr), 32'h1);
    chk("r_corr_lag0", 32'(r_corr), 32'h0);
    tick();
    chk("r_corr_lag1", 32'(r_corr), 32'h1);
    chk("r_berr_lag1", 32'(r_berr), 32'h2);
    tick();
    tick();
    chk("r1_cnt3", 32'(m_cnt), 32'h3);
    chk("r1_broken3", 32'(m_broken), 32'h0);
    setw(GOOD, GOOD, GOOD);
    tick();
    chk("r1_cnt_clean", 32'(m_cnt), 32'h3);
    setw(GOOD, BAD1, GOOD);
    tick(); tick(); tick();
    chk("r1_broken_again", 32'(m_broken), 32'h0);
    chk("r1_cnt6", 32'(m_cnt), 32'h6);

    // replica 2 wrong for 4 cycles -> broken
    setw(GOOD, GOOD, GOOD);
    tick();
    setw(GOOD, GOOD, 32'h0);
    tick(); tick(); tick();
    chk("r2_broken3", 32'(m_broken), 32'h0);
    tick();
    chk("r2_broken4", 32'(m_broken), 32'h4);
    chk("r2_cnt10", 32'(m_cnt), 32'd10);
    chk("r2_ign_berr", 32'(m_berr), 32'h0);
    chk("r2_ign_det", 32'(m_det), 32'h0);
    chk_vote("r2_ign_voted", GOOD);
    chk("r2_ign_fatal", 32'(m_fatal), 32'h0);
    tick();
    chk("r2_ign_cnt", 32'(m_cnt), 32'd10);

    // no majority with replica 2 excluded
    setw(32'h1, 32'h2, 32'h0);
    chk_vote("unc_voted", 32'h1);
    chk("unc_det", 32'(m_det), 32'h1);
    chk("unc_corr", 32'(m_corr), 32'h0);
    chk("unc_berr", 32'(m_berr), 32'h2);
    chk("unc_pre", 32'(m_unc), 32'h0);
    tick();
    chk("unc_set", 32'(m_unc), 32'h1);
    chk("unc_cnt", 32'(m_cnt), 32'd10);
    setw(32'h1, 32'h1, 32'h0);
    chk("unc_clean_det", 32'(m_det), 32'h0);
    tick();
    chk("unc_sticky", 32'(m_unc), 32'h1);

    // clear replica 2, then clear priority over a same-cycle error
    clr = 3'b100;
    setw(GOOD, GOOD, 32'h0);
    chk("clr_pre", 32'(m_broken), 32'h4);
    tick();
    clr = 3'b000;
    chk("clr_done", 32'(m_broken), 32'h0);
    tick(); tick(); tick();
    chk("clr_3err", 32'(m_broken), 32'h0);
    clr = 3'b100;
    #1;
    chk("clr_err_corr", 32'(m_corr), 32'h1);
    chk("clr_err_berr", 32'(m_berr), 32'h4);
    tick();
    clr = 3'b000;
    chk("clr_prio", 32'(m_broken), 32'h0);
    tick(); tick(); tick();
    chk("clr_prio_3err", 32'(m_broken), 32'h0);
    tick();
    chk("clr_prio_4err", 32'(m_broken), 32'h4);
    chk("clr_cnt18", 32'(m_cnt), 32'd18);
    clr = 3'b100;
    setw(GOOD, GOOD, GOOD);
    tick();
    clr = 3'b000;
    chk("clr_final", 32'(m_broken), 32'h0);

    // external break of replicas 0 and 1
    bb = 3'b011;
    setw(32'h1, 32'h2, 32'h3);
    chk("ext_fatal", 32'(m_fatal), 32'h1);
    chk_vote("ext_voted", 32'h3);
    chk("ext_broken", 32'(m_broken), 32'h3);
    chk("ext_berr", 32'(m_berr), 32'h0);
    chk("ext_det", 32'(m_det), 32'h0);
    tick();
    chk("ext_unc", 32'(m_unc), 32'h1);
    chk("ext_cnt", 32'(m_cnt), 32'd18);
    bb = 3'b000;

    // saturation on the CNT_W=2 instance, then reset mid-burst
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("sat_rst_s_cnt", 32'(s_cnt), 32'h0);
    chk("sat_rst_cnt", 32'(m_cnt), 32'h0);
    chk("sat_rst_unc", 32'(m_unc), 32'h0);
    chk("sat_rst_broken", 32'(m_broken), 32'h0);
    setw(32'h0, GOOD, GOOD); tick();
    setw(GOOD, 32'h0, GOOD); tick();
    setw(GOOD, GOOD, 32'h0); tick();
    setw(32'h0, GOOD, GOOD); tick();
    setw(GOOD, 32'h0, GOOD); tick();
    chk("sat_s_cnt", 32'(s_cnt), 32'h3);
    chk("sat_m_cnt", 32'(m_cnt), 32'h5);
    chk("sat_s_broken", 32'(s_broken), 32'h0);
    setw(GOOD, GOOD, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_s_cnt", 32'(s_cnt), 32'h0);
    chk("mid_rst_m_cnt", 32'(m_cnt), 32'h0);
    chk("mid_rst_r_corr", 32'(r_corr), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
